hex_value_editor: RTL and testbench

Interactive entry block for the 7-segment display chain. It is the input-side counterpart of the info viewer: instead of presenting fixed values on the hex digits, it lets the user compose a NUM_HEX-digit hexadecimal value with debounced key events. It shows a blinking cursor on the digit being edited and publishes the committed value to the rest of the design. It sits between the `debouncer_states` event outputs and the per-digit `seven_segment` instances.

---
 rtl/hex_editor_pkg.sv | 10 +
 rtl/blink_timer.sv | 31 +++
 rtl/hex_value_editor.sv | 90 +++++++++
 tb/tb_hex_value_editor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hex_editor_pkg.sv
// Shared types and nibble arithmetic for the hex value editor and its helpers.
package hex_editor_pkg;
  localparam int DIGIT_W = 4;

  typedef enum logic {IDLE = 1'b0, EDIT = 1'b1} state_e;

  function automatic logic [DIGIT_W-1:0] hex_step(input logic [DIGIT_W-1:0] digit, input logic up);
    return up ? digit + 4'd1 : digit - 4'd1;
  endfunction
endpackage

// File: rtl/blink_timer.sv
// Free-running half-period timer; phase starts visible (1) and toggles on each wrap.
module blink_timer #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_phase
);
  localparam int CW = $clog2(BLINK_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count   <= '0;
      o_phase <= 1'b1;
    end else if (i_restart) begin
      count   <= '0;
      o_phase <= 1'b1;
    end else if (i_enable) begin
      if (count == CW'(BLINK_CYCLES - 1)) begin
        count   <= '0;
        o_phase <= ~o_phase;
      end else begin
        count <= count + CW'(1);
      end
    end
  end
endmodule

// File: rtl/hex_value_editor.sv
// Key-driven editor for a NUM_HEX-digit hex word with blinking cursor and commit/cancel.
module hex_value_editor
  import hex_editor_pkg::*;
#(
  parameter int                       NUM_HEX      = 6,
  parameter int                       BLINK_CYCLES = 25_000_000,
  parameter logic [4*NUM_HEX-1:0]     INIT_VALUE   = '0,
  localparam int                      CW           = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_edit,
  input  logic               i_next,
  input  logic               i_inc,
  input  logic               i_dec,
  input  logic               i_commit,
  input  logic               i_cancel,
  output logic [DIGIT_W-1:0] o_hex [NUM_HEX],
  output logic [NUM_HEX-1:0] o_digit_on,
  output logic [4*NUM_HEX-1:0] o_value,
  output logic               o_valid,
  output logic [CW-1:0]      o_cursor,
  output logic               o_editing
);
  state_e             state;
  logic [CW-1:0]      cursor;
  logic [DIGIT_W-1:0] working   [NUM_HEX];
  logic [DIGIT_W-1:0] committed [NUM_HEX];
  logic               en_q;
  logic               phase;

  // Only the highest-priority event acts in a given cycle.
  logic in_edit, do_edit, do_commit, do_cancel, do_next, do_step;
  assign in_edit   = i_enable && (state == EDIT);
  assign do_edit   = i_enable && (state == IDLE) && i_edit;
  assign do_commit = in_edit && i_commit;
  assign do_cancel = in_edit && !i_commit && i_cancel;
  assign do_next   = in_edit && !i_commit && !i_cancel && i_next;
  assign do_step   = in_edit && !i_commit && !i_cancel && !i_next && (i_inc ^ i_dec);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      cursor  <= '0;
      o_valid <= 1'b0;
      en_q    <= 1'b0;
      for (int k = 0; k < NUM_HEX; k++) begin
        working[k]   <= INIT_VALUE[4*k +: 4];
        committed[k] <= INIT_VALUE[4*k +: 4];
      end
    end else begin
      o_valid <= do_commit;
      en_q    <= i_enable;
      if (do_edit) begin
        state  <= EDIT;
        cursor <= '0;
        for (int k = 0; k < NUM_HEX; k++) working[k] <= committed[k];
      end
      if (do_commit) begin
        state <= IDLE;
        for (int k = 0; k < NUM_HEX; k++) committed[k] <= working[k];
      end
      if (do_cancel) state <= IDLE;
      if (do_next) cursor <= (cursor == CW'(NUM_HEX - 1)) ? '0 : cursor + CW'(1);
      if (do_step) working[cursor] <= hex_step(working[cursor], i_inc);
    end
  end

  blink_timer #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (in_edit),
    .i_restart(do_edit || do_next),
    .o_phase  (phase)
  );

  // Pure decode of registered state; no input reaches an output combinationally.
  always_comb begin
    for (int k = 0; k < NUM_HEX; k++) begin
      o_hex[k]           = (state == EDIT) ? working[k] : committed[k];
      o_value[4*k +: 4]  = committed[k];
    end
    o_digit_on = '1;
    if (state == EDIT && en_q) o_digit_on[cursor] = phase;
  end

  assign o_cursor  = cursor;
  assign o_editing = (state == EDIT);
endmodule

// File: tb/tb_hex_value_editor.sv
// Directed bench for hex_value_editor with a per-cycle reference model and literal spot checks.
module tb_hex_value_editor;
  localparam int N     = 6;
  localparam int BLINK = 4;
  localparam logic [23:0] INIT = 24'h123456;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1, edit = 0, nxt = 0, inc = 0, dec = 0, commit = 0, cancel = 0;
  logic [3:0]  hex [N];
  logic [N-1:0] digit_on;
  logic [23:0] value;
  logic        valid;
  logic [2:0]  cursor;
  logic        editing;

  hex_value_editor #(.NUM_HEX(N), .BLINK_CYCLES(BLINK), .INIT_VALUE(INIT)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_edit(edit), .i_next(nxt),
    .i_inc(inc), .i_dec(dec), .i_commit(commit), .i_cancel(cancel),
    .o_hex(hex), .o_digit_on(digit_on), .o_value(value), .o_valid(valid),
    .o_cursor(cursor), .o_editing(editing)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference model: words as flat vectors, blink as age since last restart.
  logic        m_edit, m_valid, m_en;
  logic [23:0] m_work, m_comm;
  int          m_cur, m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edit = 0; m_valid = 0; m_en = 0; m_work = INIT; m_comm = INIT; m_cur = 0; m_age = 0;
    end else begin
      m_valid = 0;
      m_en = en;
      if (en) begin
        if (!m_edit) begin
          if (edit) begin m_edit = 1; m_work = m_comm; m_cur = 0; m_age = 0; end
        end else if (commit) begin
          m_comm = m_work; m_valid = 1; m_edit = 0;
        end else if (cancel) begin
          m_edit = 0;
        end else if (nxt) begin
          m_cur = (m_cur + 1) % N; m_age = 0;
        end else begin
          m_age++;
          if (inc != dec) begin
            int d;
            d = int'((m_work >> (4 * m_cur)) & 24'hF);
            d = inc ? (d + 1) % 16 : (d + 15) % 16;
            m_work = (m_work & ~(24'hF << (4 * m_cur))) | (24'(d) << (4 * m_cur));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [23:0] hv, exp_hex;
      logic [N-1:0] exp_on;
      for (int k = 0; k < N; k++) hv[4*k +: 4] = hex[k];
      exp_hex = m_edit ? m_work : m_comm;
      exp_on = '1;
      if (m_edit && m_en && ((m_age / BLINK) % 2) != 0) exp_on[m_cur] = 1'b0;
      chk("model.value",    32'(value),    32'(m_comm));
      chk("model.valid",    32'(valid),    32'(m_valid));
      chk("model.editing",  32'(editing),  32'(m_edit));
      chk("model.cursor",   32'(cursor),   32'(m_cur));
      chk("model.hex",      32'(hv),       32'(exp_hex));
      chk("model.digit_on", 32'(digit_on), 32'(exp_on));
    end
  end

  // ev = {edit, next, inc, dec, commit, cancel}
  task automatic pulse(input logic [5:0] ev, input logic e = 1'b1);
    {edit, nxt, inc, dec, commit, cancel} = ev;
    en = e;
    @(posedge clk); #1;
    {edit, nxt, inc, dec, commit, cancel} = '0;
    en = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] E_EDIT = 6'b100000, E_NEXT = 6'b010000, E_INC = 6'b001000,
                         E_DEC = 6'b000100, E_COMMIT = 6'b000010, E_CANCEL = 6'b000001;

  initial begin
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    chk("reset.value",    32'(value),    32'h123456);
    chk("reset.hex0",     32'(hex[0]),   32'h6);
    chk("reset.valid",    32'(valid),    32'h0);
    chk("reset.editing",  32'(editing),  32'h0);
    chk("reset.digit_on", 32'(digit_on), 32'h3F);

    // digit0 6->9, digit1 5->4
    pulse(E_EDIT);
    repeat (3) pulse(E_INC);
    pulse(E_NEXT);
    pulse(E_DEC);
    pulse(E_COMMIT);
    chk("commit.value", 32'(value), 32'h123449);
    chk("commit.valid", 32'(valid), 32'h1);
    chk("commit.idle",  32'(editing), 32'h0);
    wait_cyc(1);
    chk("commit.valid_drop", 32'(valid), 32'h0);

    pulse(E_EDIT);
    repeat (N) pulse(E_NEXT);
    chk("wrap.cursor", 32'(cursor), 32'h0);
    repeat (16) pulse(E_INC);
    chk("wrap.inc16", 32'(hex[0]), 32'h9);
    pulse(E_INC);
    pulse(E_CANCEL);
    chk("cancel.value", 32'(value), 32'h123449);
    chk("cancel.hex0",  32'(hex[0]), 32'h9);
    chk("cancel.valid", 32'(valid), 32'h0);

    pulse(E_EDIT);
    pulse(E_INC);
    pulse(E_COMMIT | E_CANCEL);
    chk("prio.value", 32'(value), 32'h12344A);
    chk("prio.valid", 32'(valid), 32'h1);

    pulse(E_EDIT);
    pulse(E_INC | E_DEC);
    chk("incdec.hex0", 32'(hex[0]), 32'hA);
    pulse(E_INC, 1'b0);
    chk("enable.hex0",     32'(hex[0]),   32'hA);
    chk("enable.digit_on", 32'(digit_on), 32'h3F);

    pulse(E_NEXT);
    chk("blink.cursor", 32'(cursor),   32'h1);
    chk("blink.on0",    32'(digit_on), 32'h3F);
    wait_cyc(3);
    chk("blink.on3",    32'(digit_on), 32'h3F);
    wait_cyc(1);
    chk("blink.off",    32'(digit_on), 32'h3D);
    wait_cyc(3);
    chk("blink.off3",   32'(digit_on), 32'h3D);
    wait_cyc(1);
    chk("blink.on_again", 32'(digit_on), 32'h3F);

    pulse(E_INC);
    #2 rst = 1'b1;
    #2;
    chk("midreset.value",   32'(value),   32'h123456);
    chk("midreset.editing", 32'(editing), 32'h0);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(1);
    chk("midreset.cursor",   32'(cursor),   32'h0);
    chk("midreset.hex0",     32'(hex[0]),   32'h6);
    chk("midreset.digit_on", 32'(digit_on), 32'h3F);
    chk("midreset.valid",    32'(valid),    32'h0);
    wait_cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
